// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter: arbiter FSM states and the
// requester identifiers carried by the read-return tag pipe.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_WAIT_READY,
        ARB_RUN,
        ARB_DRAIN,
        ARB_HALTED
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_VGA,
        REQ_UART,
        REQ_CORE
    } req_id_t;

endpackage

// File: rtl/sram_read_tag_pipe.sv
// Shift register of requester tags that follows each read through the SRAM
// controller, so read data can be steered back to whoever issued it.
module sram_read_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    flush,
    input  req_id_t push,
    output req_id_t tag,
    output logic    empty
);

    req_id_t stage_reg [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= REQ_NONE;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= REQ_NONE;
        end else begin
            stage_reg[0] <= push;
            for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign tag = stage_reg[DEPTH-1];

    // True when nothing will be left in the pipe after this edge; the last
    // stage is being delivered right now and no longer counts as owed.
    always_comb begin
        empty = (push == REQ_NONE);
        for (int i = 0; i < DEPTH-1; i++) begin
            if (stage_reg[i] != REQ_NONE) empty = 1'b0;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the single-port SRAM controller between the VGA reader, the UART
// writer and the processing core; steers read-valid back to the issuer.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int VGA_MAX_RUN  = 8,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              SRAM_ready_i,
    input  logic              quiesce_i,
    output logic              quiesced_o,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    output logic              vga_gnt_o,
    output logic              vga_rd_valid_o,
    input  logic              uart_req_i,
    input  logic [ADDR_W-1:0] uart_addr_i,
    input  logic [DATA_W-1:0] uart_wdata_i,
    output logic              uart_gnt_o,
    input  logic              core_req_i,
    input  logic              core_we_n_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] SRAM_address_o,
    output logic [DATA_W-1:0] SRAM_write_data_o,
    output logic              SRAM_we_n_o,
    input  logic [DATA_W-1:0] SRAM_read_data_i
);

    localparam int RUN_W = (VGA_MAX_RUN > 0) ? $clog2(VGA_MAX_RUN + 1) : 1;

    arb_state_t       state_reg;
    logic [RUN_W-1:0] run_cnt_reg;
    logic             rr_core_reg;
    logic             nonvga_pend;
    logic             force_nonvga;
    logic             arb_open;
    req_id_t          pick;
    req_id_t          push_tag;
    req_id_t          ret_tag;
    logic             pipe_empty;

    assign nonvga_pend  = uart_req_i | core_req_i;
    assign force_nonvga = (VGA_MAX_RUN != 0) && (run_cnt_reg == RUN_W'(VGA_MAX_RUN)) && nonvga_pend;
    assign arb_open     = (state_reg == ARB_RUN) && !quiesce_i;

    always_comb begin
        pick = REQ_NONE;
        if (vga_req_i && !force_nonvga)                  pick = REQ_VGA;
        else if (uart_req_i && (!core_req_i || !rr_core_reg)) pick = REQ_UART;
        else if (core_req_i)                             pick = REQ_CORE;
    end

    assign vga_gnt_o  = arb_open && (pick == REQ_VGA);
    assign uart_gnt_o = arb_open && (pick == REQ_UART);
    assign core_gnt_o = arb_open && (pick == REQ_CORE);

    // Losing the controller cancels the command register's write strobe
    // along with every read still in flight.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            SRAM_address_o    <= '0;
            SRAM_write_data_o <= '0;
            SRAM_we_n_o       <= 1'b1;
        end else begin
            SRAM_we_n_o <= 1'b1;
            if (SRAM_ready_i) begin
                if (vga_gnt_o) begin
                    SRAM_address_o <= vga_addr_i;
                end
                if (uart_gnt_o) begin
                    SRAM_address_o    <= uart_addr_i;
                    SRAM_write_data_o <= uart_wdata_i;
                    SRAM_we_n_o       <= 1'b0;
                end
                if (core_gnt_o) begin
                    SRAM_address_o    <= core_addr_i;
                    SRAM_write_data_o <= core_wdata_i;
                    SRAM_we_n_o       <= core_we_n_i;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            run_cnt_reg <= '0;
            rr_core_reg <= 1'b0;
        end else begin
            if (!nonvga_pend || uart_gnt_o || core_gnt_o)
                run_cnt_reg <= '0;
            else if (vga_gnt_o && run_cnt_reg != RUN_W'(VGA_MAX_RUN))
                run_cnt_reg <= run_cnt_reg + 1'b1;
            if (uart_gnt_o)      rr_core_reg <= 1'b1;
            else if (core_gnt_o) rr_core_reg <= 1'b0;
        end
    end

    always_comb begin
        push_tag = REQ_NONE;
        if (vga_gnt_o)                      push_tag = REQ_VGA;
        else if (core_gnt_o && core_we_n_i) push_tag = REQ_CORE;
    end

    sram_read_tag_pipe #(
        .DEPTH (READ_LATENCY + 1)
    ) u_tag_pipe (
        .clk    (CLOCK_50_I),
        .resetn (resetn),
        .flush  (!SRAM_ready_i),
        .push   (push_tag),
        .tag    (ret_tag),
        .empty  (pipe_empty)
    );

    assign vga_rd_valid_o  = (ret_tag == REQ_VGA);
    assign core_rd_valid_o = (ret_tag == REQ_CORE);
    assign rd_data_o       = SRAM_read_data_i;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ARB_WAIT_READY;
            quiesced_o <= 1'b0;
        end else if (!SRAM_ready_i) begin
            state_reg  <= ARB_WAIT_READY;
            quiesced_o <= 1'b0;
        end else begin
            case (state_reg)
                ARB_WAIT_READY: state_reg <= ARB_RUN;
                ARB_RUN:        if (quiesce_i) state_reg <= ARB_DRAIN;
                ARB_DRAIN: begin
                    // A quiesce withdrawn mid-drain resumes without ever halting.
                    if (pipe_empty) begin
                        if (quiesce_i) begin
                            state_reg  <= ARB_HALTED;
                            quiesced_o <= 1'b1;
                        end else begin
                            state_reg  <= ARB_RUN;
                        end
                    end
                end
                ARB_HALTED: begin
                    if (!quiesce_i) begin
                        state_reg  <= ARB_RUN;
                        quiesced_o <= 1'b0;
                    end
                end
                default: state_reg <= ARB_WAIT_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomised and directed bench for sram_access_arbiter against a
// transaction-level model of grants, SRAM commands and read returns.
module tb_sram_access_arbiter;

    localparam int ADDR_W       = 18;
    localparam int DATA_W       = 16;
    localparam int MAX_RUN      = 8;
    localparam int GNT_TO_VALID = 3;   // 1 command register + READ_LATENCY 2

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              sram_ready = 1'b0;
    logic              quiesce = 1'b0;
    logic              quiesced;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_gnt, vga_rd_valid;
    logic              uart_req = 1'b0;
    logic [ADDR_W-1:0] uart_addr = '0;
    logic [DATA_W-1:0] uart_wdata = '0;
    logic              uart_gnt;
    logic              core_req = 1'b0;
    logic              core_we_n = 1'b1;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_wdata = '0;
    logic              core_gnt, core_rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_write_data;
    logic              sram_we_n;
    logic [DATA_W-1:0] sram_read_data = '0;

    always #10 clk = ~clk;

    sram_access_arbiter dut (
        .CLOCK_50_I        (clk),
        .resetn            (resetn),
        .SRAM_ready_i      (sram_ready),
        .quiesce_i         (quiesce),
        .quiesced_o        (quiesced),
        .vga_req_i         (vga_req),
        .vga_addr_i        (vga_addr),
        .vga_gnt_o         (vga_gnt),
        .vga_rd_valid_o    (vga_rd_valid),
        .uart_req_i        (uart_req),
        .uart_addr_i       (uart_addr),
        .uart_wdata_i      (uart_wdata),
        .uart_gnt_o        (uart_gnt),
        .core_req_i        (core_req),
        .core_we_n_i       (core_we_n),
        .core_addr_i       (core_addr),
        .core_wdata_i      (core_wdata),
        .core_gnt_o        (core_gnt),
        .core_rd_valid_o   (core_rd_valid),
        .rd_data_o         (rd_data),
        .SRAM_address_o    (sram_address),
        .SRAM_write_data_o (sram_write_data),
        .SRAM_we_n_o       (sram_we_n),
        .SRAM_read_data_i  (sram_read_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: who is allowed to win, what the bus should show, and
    // which read data is owed on which cycle.
    bit                m_ready, m_stopping, m_halted, m_prefer_core;
    int                m_run;
    logic [ADDR_W-1:0] e_addr  = '0;
    logic [DATA_W-1:0] e_wdata = '0;
    logic              e_we_n  = 1'b1;
    int                due_kind [int];   // 1 = VGA, 2 = core
    logic [DATA_W-1:0] due_data [int];
    logic [DATA_W-1:0] ref_mem  [int];
    logic [DATA_W-1:0] sram_mem [int];
    logic [DATA_W-1:0] rd_line  [2];

    bit                obs_vga_gnt, obs_uart_gnt, obs_core_gnt, obs_vga_rdv, obs_core_rdv, obs_quiesced;
    int                n_vga_rdv = 0, n_core_rdv = 0;
    logic [DATA_W-1:0] vga_seen [$];

    function automatic logic [DATA_W-1:0] mem_default(input logic [ADDR_W-1:0] a);
        return a[15:0] + 16'h0100;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_default(a);
    endfunction

    // One clock cycle: entered just after a negedge with the inputs set.
    task automatic step();
        logic [DATA_W-1:0] v;
        bit pend, force_n, open_g, gv, gu, gc, outstanding;
        int kind;
        if (!sram_we_n) sram_mem[int'(sram_address)] = sram_write_data;
        v = sram_mem.exists(int'(sram_address)) ? sram_mem[int'(sram_address)] : mem_default(sram_address);
        sram_read_data = rd_line[1];
        rd_line[1] = rd_line[0];
        rd_line[0] = v;
        #1;
        pend    = uart_req | core_req;
        force_n = (m_run >= MAX_RUN) && pend;
        open_g  = m_ready && !m_stopping && !m_halted && !quiesce;
        gv = 0; gu = 0; gc = 0;
        if (open_g) begin
            if (vga_req && !force_n)     gv = 1;
            else if (uart_req && core_req) begin
                if (m_prefer_core) gc = 1; else gu = 1;
            end
            else if (uart_req)           gu = 1;
            else if (core_req)           gc = 1;
        end
        kind = due_kind.exists(cyc) ? due_kind[cyc] : 0;
        check("grant", 32'({vga_gnt, uart_gnt, core_gnt}), 32'({gv, gu, gc}));
        check("rd_valid", 32'({vga_rd_valid, core_rd_valid}), 32'({kind == 1, kind == 2}));
        if (kind != 0) check("rd_data", 32'(rd_data), 32'(due_data[cyc]));
        check("sram_we_n", 32'(sram_we_n), 32'(e_we_n));
        check("sram_addr", 32'(sram_address), 32'(e_addr));
        check("sram_wdata", 32'(sram_write_data), 32'(e_wdata));
        check("quiesced", 32'(quiesced), 32'(m_halted));
        obs_vga_gnt = vga_gnt; obs_uart_gnt = uart_gnt; obs_core_gnt = core_gnt;
        obs_vga_rdv = vga_rd_valid; obs_core_rdv = core_rd_valid; obs_quiesced = quiesced;
        if (vga_gnt)  $display("[%0d] grant VGA  read  addr=0x%05h", cyc, vga_addr);
        if (uart_gnt) $display("[%0d] grant UART write addr=0x%05h data=0x%04h", cyc, uart_addr, uart_wdata);
        if (core_gnt) $display("[%0d] grant CORE %s addr=0x%05h", cyc, core_we_n ? "read " : "write", core_addr);
        if (vga_rd_valid)  begin n_vga_rdv++;  vga_seen.push_back(rd_data); end
        if (core_rd_valid) n_core_rdv++;
        @(posedge clk);
        if (sram_ready && gv) begin
            due_kind[cyc + GNT_TO_VALID] = 1;
            due_data[cyc + GNT_TO_VALID] = ref_read(vga_addr);
            e_addr = vga_addr; e_we_n = 1'b1;
        end else if (sram_ready && gu) begin
            ref_mem[int'(uart_addr)] = uart_wdata;
            e_addr = uart_addr; e_wdata = uart_wdata; e_we_n = 1'b0;
        end else if (sram_ready && gc) begin
            if (core_we_n) begin
                due_kind[cyc + GNT_TO_VALID] = 2;
                due_data[cyc + GNT_TO_VALID] = ref_read(core_addr);
            end else begin
                ref_mem[int'(core_addr)] = core_wdata;
            end
            e_addr = core_addr; e_wdata = core_wdata; e_we_n = core_we_n;
        end else begin
            e_we_n = 1'b1;
        end
        if (!sram_ready) begin
            for (int k = 1; k <= GNT_TO_VALID; k++)
                if (due_kind.exists(cyc + k)) due_kind.delete(cyc + k);
        end
        if (!pend || gu || gc) m_run = 0;
        else if (gv)           m_run++;
        if (gu)      m_prefer_core = 1;
        else if (gc) m_prefer_core = 0;
        outstanding = 0;
        for (int k = 1; k <= GNT_TO_VALID; k++)
            if (due_kind.exists(cyc + k)) outstanding = 1;
        if (!sram_ready) begin
            m_ready = 0; m_stopping = 0; m_halted = 0;
        end else if (!m_ready) begin
            m_ready = 1;
        end else if (m_halted) begin
            if (!quiesce) m_halted = 0;
        end else if (m_stopping) begin
            if (!outstanding) begin m_stopping = 0; m_halted = quiesce; end
        end else if (quiesce) begin
            m_stopping = 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        vga_req = 0; uart_req = 0; core_req = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c, first_gnt, ready_cyc, n, arb, ucyc, prev, who, last_rdv, q_rise, base_v, base_c, cnt;
        m_ready = 0; m_stopping = 0; m_halted = 0; m_prefer_core = 0; m_run = 0;
        rd_line[0] = '0; rd_line[1] = '0;

        // Reset: requests high, nothing may be granted, bus idle.
        vga_req = 1; uart_req = 1; core_req = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_grant", 32'({vga_gnt, uart_gnt, core_gnt}), 32'(0));
        check("rst_rd_valid", 32'({vga_rd_valid, core_rd_valid}), 32'(0));
        check("rst_we_n", 32'(sram_we_n), 32'(1));
        check("rst_addr", 32'(sram_address), 32'(0));
        check("rst_wdata", 32'(sram_write_data), 32'(0));
        check("rst_quiesced", 32'(quiesced), 32'(0));
        @(negedge clk);
        uart_req = 0; core_req = 0; vga_addr = '0;
        resetn = 1;

        // 1: controller not ready for 10 cycles, then first VGA grant.
        for (int i = 0; i < 10; i++) step();
        sram_ready = 1; ready_cyc = cyc; first_gnt = -1;
        for (int i = 0; i < 4 && first_gnt < 0; i++) begin
            c = cyc; step();
            if (obs_vga_gnt) first_gnt = c;
        end
        check("first_vga_gnt_cycle", 32'(first_gnt), 32'(ready_cyc + 1));
        idle(6);

        // 2: four back-to-back VGA reads of addresses 0..3.
        vga_seen.delete();
        vga_req = 1; vga_addr = '0; n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            step();
            if (obs_vga_gnt) begin n++; vga_addr++; end
        end
        idle(8);
        check("vga_burst_len", 32'(vga_seen.size()), 32'(4));
        for (int i = 0; i < 4 && i < vga_seen.size(); i++)
            check("vga_burst_data", 32'(vga_seen[i]), 32'(16'h0100 + i));

        // 3: VGA streaming, UART write forced in on the 9th cycle.
        vga_req = 1; uart_req = 1; uart_addr = 18'h00010; uart_wdata = 16'hBEEF;
        arb = 0; ucyc = -1;
        for (int i = 0; i < 20 && ucyc < 0; i++) begin
            step(); arb++;
            if (obs_vga_gnt)  vga_addr++;
            if (obs_uart_gnt) ucyc = arb;
        end
        vga_req = 0; uart_req = 0;
        check("uart_forced_slot", 32'(ucyc), 32'(9));
        check("uart_cmd", 32'({sram_we_n, sram_address, sram_write_data}), 32'({1'b0, 18'h00010, 16'hBEEF}));
        idle(6);

        // 4: UART and core contend with VGA idle; grants alternate.
        base_v = n_vga_rdv; base_c = n_core_rdv;
        uart_req = 1; uart_addr = 18'($urandom_range(0, 63)); uart_wdata = 16'($urandom);
        core_req = 1; core_we_n = 1; core_addr = 18'($urandom_range(0, 63));
        n = 0; prev = -1;
        for (int i = 0; i < 12 && n < 8; i++) begin
            step();
            if (obs_uart_gnt || obs_core_gnt) begin
                who = obs_core_gnt ? 1 : 0;
                if (prev >= 0) check("rr_alternate", 32'(who), 32'(prev ^ 1));
                prev = who; n++;
                if (obs_uart_gnt) begin uart_addr = 18'($urandom_range(0, 63)); uart_wdata = 16'($urandom); end
                if (obs_core_gnt) core_addr = 18'($urandom_range(0, 63));
            end
        end
        idle(6);
        check("rr_grant_count", 32'(n), 32'(8));
        check("rr_core_returns", 32'(n_core_rdv - base_c), 32'(4));
        check("rr_vga_returns", 32'(n_vga_rdv - base_v), 32'(0));

        // 5: two core reads, then quiesce while core keeps requesting.
        base_c = n_core_rdv;
        core_req = 1; core_we_n = 1; core_addr = 18'h00020; n = 0;
        for (int i = 0; i < 6 && n < 2; i++) begin
            step();
            if (obs_core_gnt) begin n++; core_addr++; end
        end
        quiesce = 1; last_rdv = -1; q_rise = -1; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            c = cyc; step();
            if (obs_core_gnt || obs_uart_gnt || obs_vga_gnt) cnt++;
            if (obs_core_rdv) last_rdv = c;
            if (obs_quiesced && q_rise < 0) q_rise = c;
        end
        check("quiesce_no_grant", 32'(cnt), 32'(0));
        check("quiesce_core_returns", 32'(n_core_rdv - base_c), 32'(2));
        check("quiesced_after_last_read", 32'(q_rise - last_rdv), 32'(1));
        quiesce = 0; core_req = 0;
        idle(4);

        // 5b: quiesce withdrawn mid-drain never pulses quiesced.
        vga_req = 1; vga_addr = 18'h00033;
        for (int i = 0; i < 4 && !obs_vga_gnt; i++) step();
        vga_req = 0; quiesce = 1; step();
        quiesce = 0; cnt = 0;
        for (int i = 0; i < 8; i++) begin step(); if (obs_quiesced) cnt++; end
        check("short_quiesce_no_pulse", 32'(cnt), 32'(0));

        // 6: controller drops right after a VGA read grant.
        base_v = n_vga_rdv;
        vga_req = 1; vga_addr = 18'h00155; obs_vga_gnt = 0;
        for (int i = 0; i < 4 && !obs_vga_gnt; i++) step();
        vga_req = 0; sram_ready = 0;
        uart_req = 1; uart_addr = 18'h00021; uart_wdata = 16'h1234;
        step();
        uart_req = 0;
        check("not_ready_we_n", 32'(sram_we_n), 32'(1));
        step(); step();
        sram_ready = 1;
        for (int i = 0; i < 5; i++) step();
        check("flushed_vga_return", 32'(n_vga_rdv - base_v), 32'(0));

        // Randomised traffic with quiesce and controller-ready disturbances.
        for (int i = 0; i < 2000; i++) begin
            if (!vga_req && $urandom_range(0, 3) == 0) begin vga_req = 1; vga_addr = 18'($urandom_range(0, 63)); end
            if (!uart_req && $urandom_range(0, 4) == 0) begin
                uart_req = 1; uart_addr = 18'($urandom_range(0, 63)); uart_wdata = 16'($urandom);
            end
            if (!core_req && $urandom_range(0, 4) == 0) begin
                core_req = 1; core_we_n = 1'($urandom); core_addr = 18'($urandom_range(0, 63));
                core_wdata = 16'($urandom);
            end
            if (quiesce) begin if ($urandom_range(0, 7) == 0) quiesce = 0; end
            else if ($urandom_range(0, 49) == 0) quiesce = 1;
            if (sram_ready) begin if ($urandom_range(0, 199) == 0) sram_ready = 0; end
            else if ($urandom_range(0, 1) == 0) sram_ready = 1;
            step();
            if (obs_vga_gnt) begin
                if ($urandom_range(0, 1) == 1) vga_addr = 18'($urandom_range(0, 63)); else vga_req = 0;
            end
            if (obs_uart_gnt) uart_req = 0;
            if (obs_core_gnt) core_req = 0;
        end
        quiesce = 0; sram_ready = 1;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
